fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_bimodal_predictor.sv | 28 ++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants, fetch-queue entry type and immediate decoders for fetch_unit.
package fetch_unit_pkg;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic HIGH  = 1'b1;
    localparam logic LOW   = 1'b0;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam int DEF_PRED_BITS     = 8;
    localparam int DEF_FQ_DEPTH_BITS = 3;
    localparam logic [1:0] CTR_RESET = 2'b01;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } fq_entry_t;
    function automatic logic [31:0] b_imm(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction
    function automatic logic [31:0] j_imm(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction
endpackage

// File: rtl/fetch_unit_bimodal_predictor.sv
// bimodal_predictor: table of 2-bit saturating counters, combinational lookup, registered update.
module bimodal_predictor
    import fetch_unit_pkg::*;
#(
    parameter int PRED_BITS = DEF_PRED_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PRED_BITS-1:0] lk_idx_i,
    output logic [1:0]           lk_ctr_o,
    input  logic                 upd_en_i,
    input  logic [PRED_BITS-1:0] upd_idx_i,
    input  logic                 upd_taken_i
);
    logic [1:0] ctr_q [1 << PRED_BITS];
    logic [1:0] cur, ctr_d;
    assign lk_ctr_o = ctr_q[lk_idx_i];
    assign cur      = ctr_q[upd_idx_i];
    assign ctr_d    = upd_taken_i ? ((cur == 2'b11) ? cur : cur + 2'd1)
                                  : ((cur == 2'b00) ? cur : cur - 2'd1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < (1 << PRED_BITS); i++) ctr_q[i] <= CTR_RESET;
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= ctr_d;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: I-cache fetch stage with decoupling fetch queue and bimodal branch prediction.
// Define JAL_PRED_EN to also redirect fetch on JAL instructions.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          FQ_DEPTH_BITS = DEF_FQ_DEPTH_BITS,
    parameter int          PRED_BITS     = DEF_PRED_BITS,
    parameter logic [31:0] RESET_PC      = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_pc,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_inst,
    output logic        issue_valid,
    output logic [31:0] issue_inst,
    output logic [31:0] issue_pc,
    output logic        issue_pred,
    input  logic        rob_next_full,
    input  logic        rs_next_full,
    input  logic        lsb_next_full,
    input  logic        jump_flag,
    input  logic [31:0] target_pc,
    input  logic        upd_pred_valid,
    input  logic [31:0] upd_pred_pc,
    input  logic        upd_pred_need_jump
);
    localparam int DEPTH = 1 << FQ_DEPTH_BITS;
    localparam logic [FQ_DEPTH_BITS:0] FULL = {1'b1, {FQ_DEPTH_BITS{1'b0}}};

    fq_entry_t                fq_q [DEPTH];
    logic [31:0]              pc_q, pc_d, issue_inst_q, issue_inst_d, issue_pc_q, issue_pc_d;
    logic [FQ_DEPTH_BITS-1:0] head_q, head_d, tail_q, tail_d;
    logic [FQ_DEPTH_BITS:0]   count_q, count_d;
    logic                     issue_valid_q, issue_valid_d, issue_pred_q, issue_pred_d;
    logic                     flush_hold_q, flush_hold_d;
    logic [1:0]               ctr;
    logic                     stall, push, pop, br_taken, jal, pred;
    logic [31:0]              next_pc;
    logic                     unused;

    assign unused       = ^{upd_pred_pc[31:PRED_BITS+2], upd_pred_pc[1:0]};
    assign ic_req_valid = rdy & ~flush_hold_q & (count_q != FULL);
    assign ic_req_pc    = pc_q;
    assign stall        = rob_next_full | rs_next_full | lsb_next_full;
    assign push         = ic_req_valid & ic_resp_valid & ~jump_flag;
    assign pop          = rdy & ~stall & (count_q != '0) & ~jump_flag;
    assign br_taken     = (ic_resp_inst[6:0] == OP_BRANCH) & ctr[1];
`ifdef JAL_PRED_EN
    assign jal          = ic_resp_inst[6:0] == OP_JAL;
`else
    assign jal          = FALSE;
`endif
    assign pred         = br_taken | jal;
    assign next_pc      = pc_q + (jal ? j_imm(ic_resp_inst) : br_taken ? b_imm(ic_resp_inst) : 32'd4);

    bimodal_predictor #(.PRED_BITS(PRED_BITS)) u_pred (
        .clk        (clk),
        .rst        (rst),
        .lk_idx_i   (pc_q[PRED_BITS+1:2]),
        .lk_ctr_o   (ctr),
        .upd_en_i   (rdy & upd_pred_valid),
        .upd_idx_i  (upd_pred_pc[PRED_BITS+1:2]),
        .upd_taken_i(upd_pred_need_jump)
    );

    always_comb begin
        pc_d          = pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        flush_hold_d  = flush_hold_q;
        issue_valid_d = LOW;
        issue_inst_d  = issue_inst_q;
        issue_pc_d    = issue_pc_q;
        issue_pred_d  = issue_pred_q;
        if (rdy) begin
            flush_hold_d = jump_flag;
            if (jump_flag) begin
                pc_d    = target_pc;
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) begin
                    pc_d   = next_pc;
                    tail_d = tail_q + 1'b1;
                end
                if (pop) begin
                    issue_valid_d = HIGH;
                    issue_inst_d  = fq_q[head_q].inst;
                    issue_pc_d    = fq_q[head_q].pc;
                    issue_pred_d  = fq_q[head_q].pred;
                    head_d        = head_q + 1'b1;
                end
                count_d = count_q + {{FQ_DEPTH_BITS{1'b0}}, push} - {{FQ_DEPTH_BITS{1'b0}}, pop};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            flush_hold_q  <= LOW;
            issue_valid_q <= LOW;
            issue_inst_q  <= '0;
            issue_pc_q    <= '0;
            issue_pred_q  <= LOW;
            for (int i = 0; i < DEPTH; i++) fq_q[i] <= '0;
        end else begin
            pc_q          <= pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            flush_hold_q  <= flush_hold_d;
            issue_valid_q <= issue_valid_d;
            issue_inst_q  <= issue_inst_d;
            issue_pc_q    <= issue_pc_d;
            issue_pred_q  <= issue_pred_d;
            if (push) fq_q[tail_q] <= {ic_resp_inst, pc_q, pred};
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_inst  = issue_inst_q;
    assign issue_pc    = issue_pc_q;
    assign issue_pred  = issue_pred_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven and sequence checks for fetch_unit.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BEQ = 32'h0000_0863;
    localparam logic [31:0] JAL = 32'hFF9F_F06F;
`ifdef JAL_PRED_EN
    localparam logic [31:0] JAL_NEXT = 32'h08;
    localparam logic        JAL_PRED = 1'b1;
`else
    localparam logic [31:0] JAL_NEXT = 32'h14;
    localparam logic        JAL_PRED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, rdy, ic_req_valid, ic_resp_valid, issue_valid, issue_pred;
    logic rob_next_full, rs_next_full, lsb_next_full, jump_flag, upd_pred_valid, upd_pred_need_jump;
    logic [31:0] ic_req_pc, ic_resp_inst, issue_inst, issue_pc, target_pc, upd_pred_pc;
    int n_chk = 0;
    int n_fail = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .ic_req_valid(ic_req_valid), .ic_req_pc(ic_req_pc),
        .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
        .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_pc(issue_pc), .issue_pred(issue_pred),
        .rob_next_full(rob_next_full), .rs_next_full(rs_next_full), .lsb_next_full(lsb_next_full),
        .jump_flag(jump_flag), .target_pc(target_pc),
        .upd_pred_valid(upd_pred_valid), .upd_pred_pc(upd_pred_pc), .upd_pred_need_jump(upd_pred_need_jump)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        req;
        logic [31:0] pc;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(logic r, logic req, logic [31:0] pc, logic iv, logic [31:0] ipc);
        vec_t v;
        v.rdy = r; v.req = req; v.pc = pc; v.iv = iv; v.ipc = ipc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rdy = 1; ic_resp_valid = 0; ic_resp_inst = NOP;
        rob_next_full = 0; rs_next_full = 0; lsb_next_full = 0;
        jump_flag = 0; target_pc = 0; upd_pred_valid = 0; upd_pred_pc = 0; upd_pred_need_jump = 0;
        rst = 1;
        #1;
        chk("async_rst_issue_valid", issue_valid, 0);
        chk("async_rst_issue_pc", issue_pc, 0);
        chk("async_rst_req_pc", ic_req_pc, 32'h0);
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken);
        upd_pred_valid = 1; upd_pred_pc = pc; upd_pred_need_jump = taken;
        @(posedge clk); #1;
        upd_pred_valid = 0;
    endtask

    task automatic fetch_at(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic uv, input logic ut,
                            input logic [31:0] exp_next, input logic exp_pred);
        jump_flag = 1; target_pc = pc;
        @(posedge clk); #1;
        jump_flag = 0;
        #1 chk({tag, "_hold_req_valid"}, ic_req_valid, 0);
        @(posedge clk); #1;
        ic_resp_valid = 1; ic_resp_inst = inst;
        upd_pred_valid = uv; upd_pred_pc = pc; upd_pred_need_jump = ut;
        #1 chk({tag, "_req_valid"}, ic_req_valid, 1);
        chk({tag, "_req_pc"}, ic_req_pc, pc);
        @(posedge clk); #1;
        ic_resp_valid = 0; upd_pred_valid = 0;
        #1 chk({tag, "_next_pc"}, ic_req_pc, exp_next);
        chk({tag, "_no_bypass"}, issue_valid, 0);
        @(posedge clk); #1;
        #1 chk({tag, "_issue_valid"}, issue_valid, 1);
        chk({tag, "_issue_pc"}, issue_pc, pc);
        chk({tag, "_issue_inst"}, issue_inst, inst);
        chk({tag, "_issue_pred"}, issue_pred, exp_pred);
    endtask

    initial begin
        for (int k = 0; k < 8; k++)
            tbl[k] = mk(1, 1, 32'(4 * k), k >= 2, (k >= 2) ? 32'(4 * (k - 2)) : 32'h0);
        tbl[8]  = mk(0, 0, 32'd32, 1, 32'd24);
        tbl[9]  = mk(0, 0, 32'd32, 0, 32'd24);
        tbl[10] = mk(0, 0, 32'd32, 0, 32'd24);
        tbl[11] = mk(1, 1, 32'd32, 0, 32'd24);
        tbl[12] = mk(1, 1, 32'd36, 1, 32'd28);
        tbl[13] = mk(1, 1, 32'd40, 1, 32'd32);

        // streaming fetch with a 3-cycle rdy freeze in the middle
        do_reset();
        for (int i = 0; i < 14; i++) begin
            rdy = tbl[i].rdy; ic_resp_valid = 1; ic_resp_inst = NOP;
            #1;
            chk($sformatf("stream%0d_req_valid", i), ic_req_valid, tbl[i].req);
            chk($sformatf("stream%0d_req_pc", i), ic_req_pc, tbl[i].pc);
            chk($sformatf("stream%0d_issue_valid", i), issue_valid, tbl[i].iv);
            chk($sformatf("stream%0d_issue_pc", i), issue_pc, tbl[i].ipc);
            chk($sformatf("stream%0d_issue_pred", i), issue_pred, 0);
            @(posedge clk); #1;
        end

        // fill the queue under stall, then drain in order
        do_reset();
        begin
            int acc = 0;
            rob_next_full = 1; ic_resp_valid = 1;
            for (int c = 0; c < 20; c++) begin
                #1;
                if (c < 8) chk($sformatf("fill%0d_req_pc", c), ic_req_pc, 32'(4 * c));
                if (ic_req_valid && ic_resp_valid) acc++;
                @(posedge clk); #1;
            end
            chk("fill_accepted", 32'(acc), 8);
            #1 chk("full_req_valid", ic_req_valid, 0);
            chk("full_req_pc", ic_req_pc, 32'd32);
            chk("full_issue_valid", issue_valid, 0);
            rob_next_full = 0;
            for (int c = 0; c < 12; c++) begin
                #1;
                chk($sformatf("drain%0d_issue_valid", c), issue_valid, c >= 1);
                chk($sformatf("drain%0d_req_valid", c), ic_req_valid, c >= 1);
                if (c >= 1) begin
                    chk($sformatf("drain%0d_issue_pc", c), issue_pc, 32'(4 * (c - 1)));
                    chk($sformatf("drain%0d_req_pc", c), ic_req_pc, 32'(32 + 4 * (c - 1)));
                end
                @(posedge clk); #1;
            end
            ic_resp_valid = 0;
        end

        // flush with 5 queued entries and a colliding response
        do_reset();
        lsb_next_full = 1; ic_resp_valid = 1;
        repeat (5) begin @(posedge clk); #1; end
        lsb_next_full = 0; jump_flag = 1; target_pc = 32'h200;
        #1 chk("flush_pre_req_pc", ic_req_pc, 32'd20);
        @(posedge clk); #1;
        jump_flag = 0;
        #1 chk("flush_issue_valid", issue_valid, 0);
        chk("flush_hold_req_valid", ic_req_valid, 0);
        chk("flush_req_pc", ic_req_pc, 32'h200);
        @(posedge clk); #1;
        #1 chk("flush_new_req_valid", ic_req_valid, 1);
        chk("flush_queue_empty", issue_valid, 0);
        @(posedge clk); #1;
        #1 chk("flush_next_req_pc", ic_req_pc, 32'h204);
        chk("flush_no_bypass", issue_valid, 0);
        @(posedge clk); #1;
        #1 chk("flush_first_issue_valid", issue_valid, 1);
        chk("flush_first_issue_pc", issue_pc, 32'h200);
        ic_resp_valid = 0;

        // bimodal training, same-cycle update/lookup, saturation, rdy gating
        do_reset();
        upd(32'h40, 1); upd(32'h40, 1); upd(32'h40, 1);
        fetch_at("beq_sat3", 32'h40, BEQ, 0, 0, 32'h50, 1);
        upd(32'h40, 0);
        fetch_at("beq_ctr2_old", 32'h40, BEQ, 1, 0, 32'h50, 1);
        fetch_at("beq_ctr1", 32'h40, BEQ, 0, 0, 32'h44, 0);
        upd(32'h40, 0); upd(32'h40, 0); upd(32'h40, 1);
        rdy = 0;
        upd(32'h40, 1); upd(32'h40, 1);
        rdy = 1;
        fetch_at("beq_sat0", 32'h40, BEQ, 0, 0, 32'h44, 0);

        fetch_at("jal", 32'h10, JAL, 0, 0, JAL_NEXT, JAL_PRED);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
